// File: rtl/channel_mux_regfile_pkg.sv
// Shared register map, bit positions and status layout for the channel mux
// control-register bank.
package channel_mux_regfile_pkg;

  localparam int unsigned ADDR_CTRL       = 32'h00;
  localparam int unsigned ADDR_STATUS     = 32'h01;
  localparam int unsigned ADDR_COMMIT_CNT = 32'h02;
  localparam int unsigned ADDR_ENA_SHADOW = 32'h03;
  localparam int unsigned ADDR_SEL_BASE   = 32'h10;

  localparam int unsigned CTRL_COMMIT_BIT     = 0;
  localparam int unsigned CTRL_SYNC_EN_BIT    = 1;
  localparam int unsigned STATUS_PENDING_BIT  = 0;
  localparam int unsigned STATUS_ADDR_ERR_BIT = 1;

  localparam int unsigned CNT_W = 16;

  // Packed so that it reads back directly as STATUS[1:0].
  typedef struct packed {
    logic addr_err;
    logic pending;
  } status_t;

endpackage

// File: rtl/channel_mux_regfile_ch_bank.sv
// Shadow and active storage for one channel: the host writes the shadow copy,
// a commit copies it into the active copy that drives the mux.
module ch_bank_reg #(
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena_we,
  input  logic             ena_d,
  input  logic             sel_we,
  input  logic [SEL_W-1:0] sel_d,
  input  logic             commit,
  output logic             shadow_ena,
  output logic [SEL_W-1:0] shadow_sel,
  output logic             active_ena,
  output logic [SEL_W-1:0] active_sel
);

  // The active copy samples the shadow value held before this edge, so a
  // shadow write landing on the commit edge waits for the next commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_ena <= 1'b0;
      shadow_sel <= '0;
      active_ena <= 1'b0;
      active_sel <= '0;
    end else begin
      if (ena_we) shadow_ena <= ena_d;
      if (sel_we) shadow_sel <= sel_d;
      if (commit) begin
        active_ena <= shadow_ena;
        active_sel <= shadow_sel;
      end
    end
  end

endmodule

// File: rtl/channel_mux_regfile.sv
// Control-register bank for the channel multiplexer: host decode, CTRL/STATUS,
// commit counter, read mux and N_CH shadow/active channel banks.
module channel_mux_regfile
  import channel_mux_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int N_CH       = 4,
  parameter int SEL_W      = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_wr,
  input  logic                    i_rd,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_rd_valid,
  input  logic                    i_sync,
  output logic [N_CH-1:0]         o_ch_ena,
  output logic [N_CH*SEL_W-1:0]   o_ch_sel,
  output logic                    o_commit
);

  logic                  ctrl_hit;
  logic                  status_hit;
  logic                  cnt_hit;
  logic                  ena_hit;
  logic                  sel_hit;
  logic                  mapped;
  logic [N_CH-1:0]       sel_match;
  logic [N_CH-1:0]       shadow_ena;
  logic [SEL_W-1:0]      shadow_sel [N_CH];
  logic                  sync_en;
  logic                  commit_q;
  status_t               status;
  logic [CNT_W-1:0]      commit_cnt;
  logic                  commit_req;
  logic                  shadow_wr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_data;

  assign ctrl_hit   = (i_addr == ADDR_WIDTH'(ADDR_CTRL));
  assign status_hit = (i_addr == ADDR_WIDTH'(ADDR_STATUS));
  assign cnt_hit    = (i_addr == ADDR_WIDTH'(ADDR_COMMIT_CNT));
  assign ena_hit    = (i_addr == ADDR_WIDTH'(ADDR_ENA_SHADOW));
  assign sel_hit    = |sel_match;
  assign mapped     = ctrl_hit | status_hit | cnt_hit | ena_hit | sel_hit;

  assign shadow_wr  = i_wr & (ena_hit | sel_hit);
  assign commit_req = (i_wr & ctrl_hit & i_data[CTRL_COMMIT_BIT]) | (i_sync & sync_en);

  // Only a few low data bits are ever stored; the rest are ignored on write.
  assign unused_data = ^i_data;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign sel_match[k] = (i_addr == ADDR_WIDTH'(ADDR_SEL_BASE + k));

    ch_bank_reg #(.SEL_W(SEL_W)) u_bank (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .ena_we     (i_wr & ena_hit),
      .ena_d      (i_data[k]),
      .sel_we     (i_wr & sel_match[k]),
      .sel_d      (i_data[SEL_W-1:0]),
      .commit     (commit_q),
      .shadow_ena (shadow_ena[k]),
      .shadow_sel (shadow_sel[k]),
      .active_ena (o_ch_ena[k]),
      .active_sel (o_ch_sel[k*SEL_W +: SEL_W])
    );
  end

  // Read data comes from register state before this edge's write, so a
  // same-cycle write/read returns the old value. Unmapped reads return 0.
  always_comb begin
    rd_data = '0;
    if (ctrl_hit) begin
      rd_data[CTRL_SYNC_EN_BIT] = sync_en;
    end else if (status_hit) begin
      rd_data = DATA_WIDTH'(status);
    end else if (cnt_hit) begin
      rd_data = DATA_WIDTH'(commit_cnt);
    end else if (ena_hit) begin
      rd_data = DATA_WIDTH'(shadow_ena);
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (sel_match[k]) rd_data = DATA_WIDTH'(shadow_sel[k]);
      end
    end
  end

  // Read handshake: a one-cycle i_rd is always accepted; o_rd_valid pulses
  // exactly one cycle later with o_data, which then holds until the next read.
  // A commit request is registered into commit_q; the bank load, o_commit,
  // the counter step and the PENDING clear all happen on the following edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_en    <= 1'b0;
      commit_q   <= 1'b0;
      o_commit   <= 1'b0;
      status     <= '0;
      commit_cnt <= '0;
      o_data     <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      commit_q   <= commit_req;
      o_commit   <= commit_q;
      o_rd_valid <= i_rd;
      if (i_rd) o_data <= rd_data;
      if (commit_q) commit_cnt <= commit_cnt + CNT_W'(1);
      if (i_wr && ctrl_hit) sync_en <= i_data[CTRL_SYNC_EN_BIT];

      if (shadow_wr) begin
        status.pending <= 1'b1;
      end else if (commit_q) begin
        status.pending <= 1'b0;
      end

      if ((i_wr || i_rd) && !mapped) begin
        status.addr_err <= 1'b1;
      end else if (i_wr && status_hit && i_data[STATUS_ADDR_ERR_BIT]) begin
        status.addr_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_channel_mux_regfile.sv
// Directed bench for channel_mux_regfile with hand-computed expectations.
module tb_channel_mux_regfile;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int SW  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic [DW-1:0]   wdata = '0;
  logic            wr_en = 1'b0;
  logic            rd_en = 1'b0;
  logic            sync = 1'b0;
  logic [DW-1:0]   o_data;
  logic            o_rd_valid;
  logic [NCH-1:0]  o_ch_ena;
  logic [NCH*SW-1:0] o_ch_sel;
  logic            o_commit;

  int checks = 0;
  int failures = 0;

  channel_mux_regfile #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_CH(NCH), .SEL_W(SW)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_addr     (addr),
    .i_data     (wdata),
    .i_wr       (wr_en),
    .i_rd       (rd_en),
    .o_data     (o_data),
    .o_rd_valid (o_rd_valid),
    .i_sync     (sync),
    .o_ch_ena   (o_ch_ena),
    .o_ch_sel   (o_ch_sel),
    .o_commit   (o_commit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk({tag, "_valid"}, {31'b0, o_rd_valid}, 32'h1);
    chk(tag, o_data, exp);
    @(negedge clk);
    chk({tag, "_valid_drop"}, {31'b0, o_rd_valid}, 32'h0);
    chk({tag, "_hold"}, o_data, exp);
  endtask

  task automatic pulse_sync();
    @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  logic [7:0] map_addrs [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ena", {28'b0, o_ch_ena}, 32'h0);
    chk("rst_sel", {16'b0, o_ch_sel}, 32'h0);
    chk("rst_commit", {31'b0, o_commit}, 32'h0);
    chk("rst_rd_valid", {31'b0, o_rd_valid}, 32'h0);
    chk("rst_data", o_data, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) rd(map_addrs[i], 32'h0, $sformatf("rst_rd_%02h", map_addrs[i]));

    // Shadow writes stay invisible until a software commit
    wr(8'h03, 32'hFFFF_FFFF);
    wr(8'h12, 32'hFFFF_FFF9);
    chk("pre_commit_ena", {28'b0, o_ch_ena}, 32'h0);
    chk("pre_commit_sel", {16'b0, o_ch_sel}, 32'h0);
    rd(8'h03, 32'hF, "ena_shadow");
    rd(8'h12, 32'h9, "sel2_shadow");
    rd(8'h01, 32'h1, "status_pending");
    wr(8'h00, 32'h1);
    chk("sw_commit_early", {31'b0, o_commit}, 32'h0);
    chk("sw_commit_early_ena", {28'b0, o_ch_ena}, 32'h0);
    @(negedge clk);
    chk("sw_commit_pulse", {31'b0, o_commit}, 32'h1);
    chk("sw_commit_ena", {28'b0, o_ch_ena}, 32'hF);
    chk("sw_commit_sel", {16'b0, o_ch_sel}, 32'h0900);
    @(negedge clk);
    chk("sw_commit_pulse_end", {31'b0, o_commit}, 32'h0);
    rd(8'h02, 32'h1, "cnt_1");
    rd(8'h01, 32'h0, "status_clear");
    rd(8'h00, 32'h0, "ctrl_selfclear");

    // Armed sync commit
    wr(8'h00, 32'h2);
    rd(8'h00, 32'h2, "ctrl_sync_en");
    wr(8'h10, 32'h5);
    pulse_sync();
    @(negedge clk);
    chk("sync_commit_pulse", {31'b0, o_commit}, 32'h1);
    chk("sync_commit_sel", {16'b0, o_ch_sel}, 32'h0905);
    rd(8'h02, 32'h2, "cnt_2");

    // Disarmed sync does nothing
    wr(8'h00, 32'h0);
    wr(8'h10, 32'h7);
    pulse_sync();
    @(negedge clk);
    chk("nosync_commit", {31'b0, o_commit}, 32'h0);
    chk("nosync_sel", {16'b0, o_ch_sel}, 32'h0905);
    @(negedge clk);
    chk("nosync_commit_late", {31'b0, o_commit}, 32'h0);
    rd(8'h02, 32'h2, "cnt_nosync");
    rd(8'h01, 32'h1, "status_nosync");

    // Shadow write in the same cycle as an armed sync is included
    wr(8'h00, 32'h2);
    @(negedge clk);
    addr = 8'h11; wdata = 32'h3; wr_en = 1'b1; sync = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; sync = 1'b0;
    @(negedge clk);
    chk("samecyc_commit", {31'b0, o_commit}, 32'h1);
    chk("samecyc_sel", {16'b0, o_ch_sel}, 32'h0937);
    rd(8'h02, 32'h3, "cnt_3");
    rd(8'h01, 32'h0, "status_samecyc");

    // Unmapped accesses and sticky ADDR_ERR
    wr(8'h14, 32'hA);
    rd(8'h7F, 32'h0, "rd_unmapped");
    rd(8'h01, 32'h2, "status_addr_err");
    rd(8'h10, 32'h7, "sel0_no_alias");
    wr(8'h01, 32'h2);
    rd(8'h01, 32'h0, "status_w1c");
    chk("unmapped_ena", {28'b0, o_ch_ena}, 32'hF);
    chk("unmapped_sel", {16'b0, o_ch_sel}, 32'h0937);

    // Same-cycle read and write returns the old value
    @(negedge clk);
    addr = 8'h03; wdata = 32'h5; wr_en = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rdwr_valid", {31'b0, o_rd_valid}, 32'h1);
    chk("rdwr_old", o_data, 32'hF);
    rd(8'h03, 32'h5, "rdwr_new");

    // Shadow write on the commit edge keeps PENDING and misses that commit
    @(negedge clk);
    addr = 8'h00; wdata = 32'h1; wr_en = 1'b1;
    @(negedge clk);
    addr = 8'h13; wdata = 32'h2;
    @(negedge clk);
    wr_en = 1'b0;
    chk("late_wr_commit", {31'b0, o_commit}, 32'h1);
    chk("late_wr_ena", {28'b0, o_ch_ena}, 32'h5);
    chk("late_wr_sel", {16'b0, o_ch_sel}, 32'h0937);
    rd(8'h01, 32'h1, "status_keep_pending");
    rd(8'h02, 32'h4, "cnt_4");
    wr(8'h00, 32'h1);
    @(negedge clk);
    chk("late_wr_sel_next", {16'b0, o_ch_sel}, 32'h2937);
    rd(8'h01, 32'h0, "status_after_second");
    rd(8'h02, 32'h5, "cnt_5");

    // Back-to-back commit requests
    @(negedge clk);
    addr = 8'h00; wdata = 32'h1; wr_en = 1'b1;
    repeat (3) @(negedge clk);
    wr_en = 1'b0;
    chk("b2b_commit_d", {31'b0, o_commit}, 32'h1);
    @(negedge clk);
    chk("b2b_commit_e", {31'b0, o_commit}, 32'h1);
    @(negedge clk);
    chk("b2b_commit_f", {31'b0, o_commit}, 32'h0);
    rd(8'h02, 32'h8, "cnt_8");

    // Simultaneous software and sync request count once
    wr(8'h00, 32'h2);
    @(negedge clk);
    addr = 8'h00; wdata = 32'h3; wr_en = 1'b1; sync = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; sync = 1'b0;
    @(negedge clk);
    chk("dual_req_pulse", {31'b0, o_commit}, 32'h1);
    @(negedge clk);
    chk("dual_req_single", {31'b0, o_commit}, 32'h0);
    rd(8'h02, 32'h9, "cnt_9");

    // Drive the counter to 0xFFFF, then wrap
    @(negedge clk);
    sync = 1'b1;
    repeat (65526) @(negedge clk);
    sync = 1'b0;
    @(negedge clk);
    rd(8'h02, 32'hFFFF, "cnt_ffff");
    @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0; addr = 8'h02; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("wrap_commit_pulse", {31'b0, o_commit}, 32'h1);
    chk("cnt_pre_increment", o_data, 32'hFFFF);
    rd(8'h02, 32'h0, "cnt_wrap");

    // Asynchronous reset mid-sequence with a commit pending
    @(negedge clk);
    addr = 8'h03; rd_en = 1'b1; sync = 1'b1;
    @(posedge clk);
    #2;
    chk("pre_rst_valid", {31'b0, o_rd_valid}, 32'h1);
    rst_n = 1'b0; rd_en = 1'b0; sync = 1'b0;
    #1;
    chk("async_rst_data", o_data, 32'h0);
    chk("async_rst_valid", {31'b0, o_rd_valid}, 32'h0);
    chk("async_rst_ena", {28'b0, o_ch_ena}, 32'h0);
    chk("async_rst_sel", {16'b0, o_ch_sel}, 32'h0);
    chk("async_rst_commit", {31'b0, o_commit}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_commit", {31'b0, o_commit}, 32'h0);
    chk("post_rst_ena", {28'b0, o_ch_ena}, 32'h0);
    rd(8'h02, 32'h0, "post_rst_cnt");
    rd(8'h01, 32'h0, "post_rst_status");
    rd(8'h00, 32'h0, "post_rst_ctrl");
    rd(8'h03, 32'h0, "post_rst_ena_shadow");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
